// File: rtl/dpa_pkg.sv
// Shared types for the masked multiplier: operation enum and the
// randomness index used for each share pair of one bit.
package dpa_pkg;

  typedef enum logic {
    DPA_OP_AND = 1'b0,
    DPA_OP_XOR = 1'b1
  } dpa_op_e;

  // Position of pair (i,j) in the upper triangle, row-major, i!=j.
  function automatic int dpa_r_index(
    input int i,
    input int j,
    input int n
  );
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/dpa_mul_lane.sv
// One bit lane: combinational share products (p_o) from the operands,
// and the integration XOR (q_o) over the registered products (p_i).
module dpa_mul_lane
  import dpa_pkg::*;
#(
  parameter int N   = 3,
  parameter int RPB = N * (N - 1) / 2
) (
  input  logic           op,
  input  logic [N-1:0]   x_b,
  input  logic [N-1:0]   y_b,
  input  logic [RPB-1:0] r_b,
  output logic [N*N-1:0] p_o,
  input  logic [N*N-1:0] p_i,
  output logic [N-1:0]   q_o
);

  logic is_xor;

  assign is_xor = (dpa_op_e'(op) == DPA_OP_XOR);

  for (genvar i = 0; i < N; i++) begin : g_i
    for (genvar j = 0; j < N; j++) begin : g_j
      if (i == j) begin : g_dom
        assign p_o[i*N+j] = is_xor ? (x_b[i] ^ y_b[j])
                                   : (x_b[i] & y_b[j]);
      end else begin : g_cross
        localparam int K = dpa_r_index(i, j, N);
        // Cross term is masked before it is registered.
        assign p_o[i*N+j] = is_xor ? 1'b0
                                   : ((x_b[i] & y_b[j]) ^ r_b[K]);
      end
    end
  end

  always_comb begin
    q_o = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        q_o[i] = q_o[i] ^ p_i[i*N+j];
      end
    end
  end

endmodule

// File: rtl/dpa_nbit_mul_pipe.sv
// Two-stage masked AND/XOR on Boolean shares with valid/ready handshake.
// Ports: clock/reset_n, in_*/op/x/y, r/r_valid/r_ready, out_*/q, r_count.
module dpa_nbit_mul_pipe
  import dpa_pkg::*;
#(
  parameter  int NUMBER_OF_SHARES = 3,
  parameter  int WIDTH            = 8,
  localparam int R_PER_BIT = NUMBER_OF_SHARES * (NUMBER_OF_SHARES - 1) / 2,
  localparam int R_WIDTH   = WIDTH * R_PER_BIT
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     op,
  input  logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]   x,
  input  logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]   y,
  input  logic [R_WIDTH-1:0]                       r,
  input  logic                                     r_valid,
  output logic                                     r_ready,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]   q,
  output logic [31:0]                              r_count
);

  localparam int N = NUMBER_OF_SHARES;

  logic                         s1_valid_q, s1_valid_d;
  logic                         out_valid_q, out_valid_d;
  logic [WIDTH-1:0][N*N-1:0]    p_q, p_d, p_c;
  logic [N-1:0][WIDTH-1:0]      q_q, q_d;
  logic [WIDTH-1:0][N-1:0]      q_c;
  logic [31:0]                  r_count_q, r_count_d;
  logic                         s1_advance;
  logic                         is_and;
  logic                         xfer;

  assign is_and     = (dpa_op_e'(op) == DPA_OP_AND);
  assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign xfer       = in_valid && in_ready && (!is_and || r_valid);
  assign r_ready    = xfer && is_and;

  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r_count   = r_count_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N-1:0] x_b;
    logic [N-1:0] y_b;
    for (genvar i = 0; i < N; i++) begin : g_sh
      assign x_b[i] = x[i][b];
      assign y_b[i] = y[i][b];
    end
    dpa_mul_lane #(
      .N   (N),
      .RPB (R_PER_BIT)
    ) u_lane (
      .op  (op),
      .x_b (x_b),
      .y_b (y_b),
      .r_b (r[b*R_PER_BIT +: R_PER_BIT]),
      .p_o (p_c[b]),
      .p_i (p_q[b]),
      .q_o (q_c[b])
    );
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    q_d         = q_q;
    r_count_d   = r_count_q;
    if (xfer) begin
      s1_valid_d = 1'b1;
      p_d        = p_c;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
    if (s1_advance) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < N; i++) begin
        for (int b = 0; b < WIDTH; b++) begin
          q_d[i][b] = q_c[b][i];
        end
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (r_ready) begin
      r_count_d = r_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      q_q         <= '0;
      r_count_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      q_q         <= q_d;
      r_count_q   <= r_count_d;
    end
  end

endmodule

// File: tb/tb_dpa_nbit_mul_pipe.sv
// Directed bench for dpa_nbit_mul_pipe at N=3, W=4 with a handshake
// model and a scoreboard of expected result shares.
module tb_dpa_nbit_mul_pipe;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [2:0][3:0]  x;
  logic [2:0][3:0]  y;
  logic [11:0]      r;
  logic             r_valid;
  logic             r_ready;
  logic             out_valid;
  logic             out_ready;
  logic [2:0][3:0]  q;
  logic [31:0]      r_count;

  typedef struct {
    logic [2:0][3:0] q;
    logic [3:0]      u;
  } exp_t;

  exp_t sb[$];

  int checks;
  int failures;
  int stall_left;
  logic m_s1;
  logic m_out;
  logic [31:0] m_rc;
  logic last_xf;
  logic rec_on;
  logic [15:0] seen0, seen1, seen2;

  dpa_nbit_mul_pipe #(
    .NUMBER_OF_SHARES (3),
    .WIDTH            (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .r         (r),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r_count   (r_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mdl(input logic o, input logic [2:0][3:0] xs,
                               input logic [2:0][3:0] ys,
                               input logic [11:0] rs);
    exp_t e;
    int lo, hi, k;
    logic [3:0] xx, yy;
    e.q = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          if (i == j) begin
            e.q[i][b] = e.q[i][b] ^
              (o ? (xs[i][b] ^ ys[i][b]) : (xs[i][b] & ys[i][b]));
          end else if (!o) begin
            lo = (i < j) ? i : j;
            hi = (i < j) ? j : i;
            k  = (lo == 0) ? hi - 1 : 2;
            e.q[i][b] = e.q[i][b] ^ (xs[i][b] & ys[j][b]) ^ rs[b*3+k];
          end
        end
      end
    end
    xx  = xs[0] ^ xs[1] ^ xs[2];
    yy  = ys[0] ^ ys[1] ^ ys[2];
    e.u = o ? (xx ^ yy) : (xx & yy);
    return e;
  endfunction

  task automatic step();
    logic adv, pop, xf, rdy;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
    @(negedge clock);
    adv = m_s1 && (!m_out || out_ready);
    pop = m_out && out_ready;
    rdy = !m_s1 || adv;
    xf  = in_valid && rdy && (op || r_valid);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_out);
    chk("r_ready", r_ready, xf && !op);
    chk("r_count", r_count, m_rc);
    if (m_out && sb.size() > 0) begin
      chk("q_shares", q, sb[0].q);
      chk("q_unmask", q[0] ^ q[1] ^ q[2], sb[0].u);
      if (pop) begin
        if (rec_on) begin
          seen0[q[0]] = 1'b1;
          seen1[q[1]] = 1'b1;
          seen2[q[2]] = 1'b1;
        end
        void'(sb.pop_front());
      end
    end
    if (xf) begin
      sb.push_back(mdl(op, x, y, r));
      if (!op) m_rc = m_rc + 32'd1;
    end
    m_out   = adv ? 1'b1 : (pop ? 1'b0 : m_out);
    m_s1    = xf ? 1'b1 : (adv ? 1'b0 : m_s1);
    last_xf = xf;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic o, input logic [2:0][3:0] xs,
                      input logic [2:0][3:0] ys, input logic [11:0] rs,
                      input logic rv);
    op = o; x = xs; y = ys; r = rs; r_valid = rv; in_valid = 1'b1;
    last_xf = 1'b0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (last_xf) break;
    end
    chk("send_accept", last_xf, 1'b1);
    in_valid = 1'b0;
    r_valid  = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      if (sb.size() == 0 && !m_out) break;
      step();
    end
    chk("drain", sb.size(), 0);
  endtask

  function automatic logic [2:0][3:0] rnd_sh(input logic [3:0] v);
    logic [2:0][3:0] s;
    s[0] = 4'($urandom);
    s[1] = 4'($urandom);
    s[2] = v ^ s[0] ^ s[1];
    return s;
  endfunction

  initial begin
    logic [2:0][3:0] xa, ya;
    logic [31:0] rc0;
    checks = 0; failures = 0; stall_left = 0;
    m_s1 = 1'b0; m_out = 1'b0; m_rc = '0; last_xf = 1'b0;
    rec_on = 1'b0; seen0 = '0; seen1 = '0; seen2 = '0;
    reset_n = 1'b0; in_valid = 1'b0; op = 1'b0;
    x = '0; y = '0; r = '0; r_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_q", q, 12'h000);
    chk("rst_r_count", r_count, 32'd0);
    reset_n = 1'b1;

    xa[0] = 4'h3; xa[1] = 4'h5; xa[2] = 4'hC;
    ya[0] = 4'h1; ya[1] = 4'h2; ya[2] = 4'h5;

    // Scenario 1: AND with r=0.
    send(1'b0, xa, ya, 12'h000, 1'b1);
    drain();
    chk("s1_r_count", r_count, 32'd1);

    // Scenario 2: XOR, no randomness.
    send(1'b1, xa, ya, 12'h000, 1'b0);
    drain();
    chk("s2_r_count", r_count, 32'd1);

    // Scenario 3: 16 random AND beats with a 5-cycle sink stall.
    for (int i = 0; i < 16; i++) begin
      if (i == 5) stall_left = 5;
      send(1'b0, 12'($urandom), 12'($urandom),
           12'($urandom_range(0, 4095)), 1'b1);
    end
    drain();
    chk("s3_r_count", r_count, 32'd17);

    // Scenario 4: AND waits for randomness.
    rc0 = r_count;
    op = 1'b0; x = xa; y = ya; r = 12'h5A3; r_valid = 1'b0;
    in_valid = 1'b1;
    repeat (3) step();
    chk("s4_no_consume", r_count, rc0);
    send(1'b0, xa, ya, 12'h5A3, 1'b1);
    drain();
    chk("s4_r_count", r_count, rc0 + 32'd1);

    // Scenario 5: reset with two beats in flight.
    send(1'b0, xa, ya, 12'hFFF, 1'b1);
    send(1'b1, xa, ya, 12'h000, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("s5_out_valid", out_valid, 1'b0);
    chk("s5_q", q, 12'h000);
    chk("s5_r_count", r_count, 32'd0);
    sb.delete();
    m_s1 = 1'b0; m_out = 1'b0; m_rc = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) step();

    // Scenario 6: fixed x=A, y=6 under random masks.
    rec_on = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send(1'b0, rnd_sh(4'hA), rnd_sh(4'h6),
           12'($urandom_range(0, 4095)), 1'b1);
    end
    drain();
    rec_on = 1'b0;
    chk("s6_q0_varies", $countones(seen0) > 1, 1'b1);
    chk("s6_q1_varies", $countones(seen1) > 1, 1'b1);
    chk("s6_q2_varies", $countones(seen2) > 1, 1'b1);
    chk("s6_r_count", r_count, 32'd24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpa_nbit_mul_pipe.md
DPA_NBIT_MUL_PIPE -- requirements
Module: dpa_nbit_mul_pipe

Interface
REQ-001 The block SHALL expose parameter NUMBER_OF_SHARES, default 3, number of Boolean shares per bit (legal range 2..8).
REQ-002 The block SHALL expose parameter WIDTH, default 8, data bits per share.
REQ-003 The block SHALL derive localparam R_PER_BIT = NUMBER_OF_SHARES*(NUMBER_OF_SHARES-1)/2 and R_WIDTH = WIDTH*R_PER_BIT.
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 Ports SHALL be, in order:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, async active-low reset.
- in_valid, input, 1, operand beat offered.
- in_ready, output, 1, block accepts beat.
- op, input, 1, 0 = masked AND, 1 = masked XOR.
- x, input, [NUMBER_OF_SHARES][WIDTH], shares of x.
- y, input, [NUMBER_OF_SHARES][WIDTH], shares of y.
- r, input, R_WIDTH, fresh randomness.
- r_valid, input, 1, randomness available.
- r_ready, output, 1, randomness consumed this cycle.
- out_valid, output, 1, result beat valid.
- out_ready, input, 1, sink accepts result.
- q, output, [NUMBER_OF_SHARES][WIDTH], shares of result.
- r_count, output, 32, total randomness words consumed.

Function
REQ-006 An input transfer SHALL occur on a rising edge when in_valid && in_ready && (op==1 || r_valid).
REQ-007 in_ready SHALL equal !s1_valid || s1_advance, where s1_advance = s1_valid && (!out_valid || out_ready). It SHALL not depend on in_valid.
REQ-008 r_ready SHALL be 1 exactly in cycles where an op==0 transfer occurs. An XOR transfer SHALL consume no randomness.
REQ-009 For AND, stage 1 SHALL register, per bit b and share pair (i,j):
- p[i][i] = x_i & y_i.
- p[i][j] = (x_i & y_j) ^ r[b*R_PER_BIT + k], for i != j.
- k = lo*N - lo*(lo+1)/2 + (hi-lo-1), with lo = min(i,j), hi = max(i,j), N = NUMBER_OF_SHARES.
REQ-010 For XOR, stage 1 SHALL register p[i][i] = x_i ^ y_i and p[i][j] = 0 for i != j.
REQ-011 No cross-domain term SHALL be combined with another share domain before the stage-1 register.
REQ-012 Stage 2 SHALL register q_i = XOR over j of p[i][j] and assert out_valid.
REQ-013 Latency SHALL be exactly 2 cycles from transfer edge to out_valid with no backpressure. Throughput SHALL be 1 beat per cycle.
REQ-014 While out_valid && !out_ready, q and out_valid SHALL hold stable. Stage 1 SHALL hold if occupied. No beat SHALL be lost or duplicated.
REQ-015 A simultaneous output handshake and input transfer with a full pipeline SHALL advance both stages in the same cycle.
REQ-016 In_valid with op==0 and r_valid==0 SHALL stall with no state change; in_ready may remain 1.
REQ-017 r_count SHALL increment by 1 per r_ready cycle and wrap from 0xFFFFFFFF to 0.
REQ-018 XOR over shares of q SHALL equal (XOR x shares) op (XOR y shares) for every beat.

Reset
REQ-019 Asserting reset_n low SHALL immediately clear s1_valid, out_valid, all p and q share registers, and r_count to 0.
REQ-020 Reset mid-operation SHALL discard in-flight beats; no out_valid SHALL appear for them after release.
REQ-021 in_ready SHALL read 1 in the first cycle after release.

Structure
REQ-022 Package dpa_pkg SHALL hold the op enum (DPA_OP_AND, DPA_OP_XOR) and the r-index function of REQ-009.
REQ-023 A per-bit sub-module dpa_mul_lane SHALL implement the combinational stage-1 products and the integration XOR, instantiated WIDTH times. Registers and handshake SHALL stay in the top.

Verification (N=3, W=4)
REQ-024 Scenario 1, AND: x shares 3,5,C (x=A), y shares 1,2,5 (y=6), r=0 -> out_valid 2 cycles later, XOR of q = 2, r_ready pulsed once, r_count=1.
REQ-025 Scenario 2, XOR: same operands, r_valid=0 -> XOR of q = C, r_ready never asserted, r_count=0.
REQ-026 Scenario 3, back-to-back: 16 random AND beats with out_ready held 0 for 5 cycles mid-stream -> all 16 results in order and correct, q stable while stalled, in_ready low only when both stages are full.
REQ-027 Scenario 4: op=0, in_valid=1, r_valid=0 for 3 cycles, then r_valid=1 -> exactly one transfer, result correct, r_count=1.
REQ-028 Scenario 5: assert reset_n low with two beats in flight -> out_valid=0 and q=0 at once, no stale output after release, r_count=0.
REQ-029 Scenario 6, share independence: fix x=A, y=6, sweep random r and masks -> unmasked result always 2 and each q_i distribution non-constant.
